// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    function automatic int unsigned sa_slices(input int unsigned w, input int unsigned n);
        return w / n;
    endfunction

    // Floor of 1 keeps the counter a legal vector when SLICES is 1 during elaboration checks.
    function automatic int unsigned sa_cnt_width(input int unsigned w, input int unsigned n);
        return ($clog2(w / n) < 1) ? 1 : $clog2(w / n);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_adder.sv
// N-bit carry-ripple adder slice time-shared by serial_add_ctrl.
module adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] result,
    output logic         cout0
);

    logic w_carry;

    always_comb begin
        w_carry = cin;
        result  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            result[i] = a[i] ^ b[i] ^ w_carry;
            w_carry   = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout0 = w_carry;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// W-bit add sequenced LSB-first through one N-bit adder slice.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned SLICES = sa_slices(W, N);
    localparam int unsigned CW     = sa_cnt_width(W, N);
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    generate
        if ((W % N) != 0 || SLICES < 2) begin : g_bad_params
            $error("serial_add_ctrl: W must be a multiple of N with W/N >= 2");
        end
    endgenerate

    sa_state_t      r_state, w_next;
    logic           w_load, w_step;
    logic [W-1:0]   r_a, r_b;
    logic           r_carry;
    logic [W-N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy, r_done, r_cout, r_ovf;
    logic [W-1:0]   r_result;
    logic [N-1:0]   w_b_slice, w_sum;
    logic           w_cout, w_cin_load;
    logic [W-1:0]   w_acc_next;

`ifdef SERIAL_ADD_SUB_EN
    logic r_sub;
    assign w_b_slice  = r_b[N-1:0] ^ {N{r_sub}};
    assign w_cin_load = sub ? 1'b1 : cin;
`else
    assign w_b_slice  = r_b[N-1:0];
    assign w_cin_load = cin;
`endif

    adder #(.N(N)) u_adder (
        .a      (r_a[N-1:0]),
        .b      (w_b_slice),
        .cin    (r_carry),
        .result (w_sum),
        .cout0  (w_cout)
    );

    // Only the upper W-N bits need storing; the final slice lands straight in result.
    assign w_acc_next = {w_sum, r_acc};

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                if (start) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == RUN) && (w_next == DONE);
            if (w_load) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= w_cin_load;
                r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                r_sub   <= sub;
`endif
            end else if (w_step) begin
                r_a     <= r_a >> N;
                r_b     <= r_b >> N;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CW'(1);
                r_acc   <= w_acc_next[W-1:N];
                if (r_cnt == LAST) begin
                    r_result <= w_acc_next;
                    r_cout   <= w_cout;
                    r_ovf    <= (r_a[N-1] == w_b_slice[N-1]) && (w_sum[N-1] != r_a[N-1]);
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (N=4, W=16); subtract cases need SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int n_pass  = 0;
    int n_total = 0;

    serial_add_ctrl #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation; returns edges from edge 0 to done and busy cycles seen.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          output int edges, output int busy_cycles);
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
            if (busy) busy_cycles++;
        end
    endtask

    int e, bc, ndone;

    initial begin
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // 0x00FF + 0x0001
        run_op(16'h00FF, 16'h0001, 1'b0, e, bc);
        check("t1_done_edge", 32'(e), 32'd4);
        check("t1_busy_cycles", 32'(bc), 32'd5);
        check("t1_result", 32'(result), 32'h0100);
        check("t1_cout", 32'(cout), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_hold", 32'(result), 32'h0100);

        run_op(16'hFFFF, 16'h0001, 1'b0, e, bc);
        check("t2_result", 32'(result), 32'h0000);
        check("t2_cout", 32'(cout), 32'd1);
        check("t2_ovf", 32'(ovf), 32'd0);
        tick();

        run_op(16'h7FFF, 16'h0001, 1'b0, e, bc);
        check("t3_result", 32'(result), 32'h8000);
        check("t3_cout", 32'(cout), 32'd0);
        check("t3_ovf", 32'(ovf), 32'd1);
        tick();

        // Reset while slice 2 is in flight
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_ovf", 32'(ovf), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);

        // Back-to-back with start held through DONE
        run_op(16'h1234, 16'h1111, 1'b1, e, bc);
        check("t4_done_edge", 32'(e), 32'd4);
        check("t4_result", 32'(result), 32'h2346);
        check("t4_cout", 32'(cout), 32'd0);
        a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_hold", 32'(result), 32'h2346);
        e = 0;
        while (!done && e < 20) begin
            tick();
            e++;
        end
        check("b2b_done_edge", 32'(e), 32'd4);
        check("b2b_result", 32'(result), 32'h0000);
        check("b2b_cout", 32'(cout), 32'd1);
        check("b2b_ovf", 32'(ovf), 32'd1);
        tick();

        // start during RUN is ignored
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) begin
                ndone++;
                check("ign_result", 32'(result), 32'h0003);
            end
        end
        check("ign_one_done", 32'(ndone), 32'd1);
        check("ign_hold", 32'(result), 32'h0003);
        check("ign_idle", 32'(busy), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, e, bc);
        check("sub1_result", 32'(result), 32'hFFFE);
        check("sub1_cout", 32'(cout), 32'd0);
        check("sub1_ovf", 32'(ovf), 32'd0);
        tick();
        run_op(16'h8000, 16'h0001, 1'b0, e, bc);
        check("sub2_result", 32'(result), 32'h7FFF);
        check("sub2_cout", 32'(cout), 32'd1);
        check("sub2_ovf", 32'(ovf), 32'd1);
        sub = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
